// File: rtl/eight_to_thirty_two.sv
// Byte-to-word assembler: one start strobe, then four bytes MSB first, rebuilt into a 32-bit word.
// Optional saturating completed-word counter compiled in with E2T_WORD_CNT_EN.
//
// state | meaning
// IDLE  | waiting for rx_start
// B0    | capturing bits 31:24
// B1    | capturing bits 23:16
// B2    | capturing bits 15:8
// B3    | capturing bits 7:0, loading data_out
module eight_to_thirty_two (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic [7:0]  data_in,
    input  logic        err_clr,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        err_overlap,
    output logic [15:0] word_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] asm_buf;
    logic        load;
    logic        set_err;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rx_start ? B0 : IDLE;
            B0:      state_nxt = B1;
            B1:      state_nxt = B2;
            B2:      state_nxt = B3;
            B3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        load    = (state == B3);
        set_err = rx_start && (state != IDLE);
    end

    // Overlapping strobes only raise the flag; the word in flight is unaffected.
    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf     <= 32'h0;
            data_out    <= 32'h0;
            data_valid  <= 1'b0;
            err_overlap <= 1'b0;
        end else begin
            data_valid <= load;
            case (state)
                B0:      asm_buf[31:24] <= data_in;
                B1:      asm_buf[23:16] <= data_in;
                B2:      asm_buf[15:8]  <= data_in;
                default: asm_buf        <= asm_buf;
            endcase
            if (load) begin
                data_out <= {asm_buf[31:8], data_in};
            end
            if (set_err) begin
                err_overlap <= 1'b1;
            end else if (err_clr) begin
                err_overlap <= 1'b0;
            end
        end
    end

`ifdef E2T_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= 16'h0;
        end else if (load && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_eight_to_thirty_two.sv
// Scoreboard bench for eight_to_thirty_two: an edge-indexed reference model predicts words,
// busy, overlap flag and word count; a negedge monitor compares every cycle.
module tb_eight_to_thirty_two;

    logic        div_8_clk = 1'b0;
    logic        rst_n;
    logic        rx_start;
    logic [7:0]  data_in;
    logic        err_clr;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        err_overlap;
    logic [15:0] word_cnt;

    eight_to_thirty_two dut (
        .div_8_clk   (div_8_clk),
        .rst_n       (rst_n),
        .rx_start    (rx_start),
        .data_in     (data_in),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .err_overlap (err_overlap),
        .word_cnt    (word_cnt)
    );

    always #5 div_8_clk = ~div_8_clk;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_start = -100;
    logic [31:0] acc;
    logic [31:0] exp_dout;
    logic        exp_err;
    logic [15:0] exp_cnt;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        last_start = -100;
        acc        = 32'h0;
        exp_dout   = 32'h0;
        exp_err    = 1'b0;
        exp_cnt    = 16'h0;
    endtask

    // A start accepted at edge e owns the bytes sampled at edges e+1..e+4; the
    // word appears on data_out after edge e+4.
    task automatic model_edge();
        int  d;
        bit  inwin;
        if (!rst_n) return;
        d     = cyc - last_start;
        inwin = (d >= 1) && (d <= 4);
        if (inwin) begin
            acc = acc | (32'(data_in) << (8 * (4 - d)));
            if (d == 4) begin
                sb.push_back('{word: acc, cyc: cyc});
                exp_dout = acc;
`ifdef E2T_WORD_CNT_EN
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
        end
        if (rx_start && inwin) begin
            exp_err = 1'b1;
        end else begin
            if (rx_start) begin
                last_start = cyc;
                acc        = 32'h0;
            end
            if (err_clr) exp_err = 1'b0;
        end
    endtask

    task automatic drive_cycle(input logic s, input logic [7:0] b, input logic c);
        rx_start = s;
        data_in  = b;
        err_clr  = c;
        @(posedge div_8_clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        drive_cycle(1'b1, 8'h00, 1'b0);
        for (int i = 3; i >= 0; i--) drive_cycle(1'b0, w[8*i +: 8], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'($urandom), 1'b0);
    endtask

    always @(negedge div_8_clk) begin
        if (mon_en) begin
            int   d;
            logic exp_busy;
            logic exp_v;
            exp_t e;
            d        = cyc - last_start;
            exp_busy = rst_n && (d >= 0) && (d <= 3);
            exp_v    = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("err_overlap", 32'(err_overlap), 32'(exp_err));
            chk("data_out", data_out, exp_dout);
            chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
            chk("data_valid", 32'(data_valid), 32'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                if (data_valid) chk("word", data_out, e.word);
            end
            while ((sb.size() > 0) && (sb[0].cyc < cyc)) begin
                e = sb.pop_front();
                chk("stale_word", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        rx_start = 1'b0;
        data_in  = 8'h00;
        err_clr  = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        idle(3);

        send_word(32'hDEADBEEF);
        idle(3);

        send_word(32'h11223344);
        send_word(32'h55667788);
        idle(3);

        drive_cycle(1'b1, 8'h00, 1'b0);
        drive_cycle(1'b0, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h02, 1'b0);
        drive_cycle(1'b0, 8'h03, 1'b0);
        drive_cycle(1'b0, 8'h04, 1'b0);
        idle(4);
        drive_cycle(1'b0, 8'h00, 1'b1);
        idle(2);

        drive_cycle(1'b1, 8'h00, 1'b0);
        drive_cycle(1'b0, 8'hC1, 1'b0);
        drive_cycle(1'b0, 8'hC2, 1'b0);
        drive_cycle(1'b1, 8'hC3, 1'b1);
        drive_cycle(1'b0, 8'hC4, 1'b0);
        idle(2);
        drive_cycle(1'b0, 8'h00, 1'b1);
        idle(1);

        drive_cycle(1'b1, 8'h00, 1'b0);
        drive_cycle(1'b0, 8'h77, 1'b0);
        drive_cycle(1'b0, 8'h66, 1'b0);
        rst_n = 1'b0;
        model_reset();
        drive_cycle(1'b0, 8'h55, 1'b0);
        drive_cycle(1'b0, 8'h44, 1'b0);
        rst_n = 1'b1;
        idle(10);
        send_word(32'hA5A55A5A);
        idle(2);

`ifdef E2T_WORD_CNT_EN
        force dut.word_cnt_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        #1;
        release dut.word_cnt_q;
        idle(1);
`endif
        for (int i = 0; i < 3; i++) begin
            send_word($urandom);
            idle(1);
        end

        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(8);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
